// File: rtl/usb_fs_rx_pkt_decode.sv
// USB full-speed receive packet decoder: PID/CRC5/CRC16/length checks, token field extraction, data forwarding.
// One clock of latency from rx_* strobes to outputs. There is no backpressure; bytes are consumed as they arrive.
module usb_fs_rx_pkt_decode #(
  parameter int MAX_PKT_BYTES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_sop,
  input  logic        rx_byte_valid,
  input  logic [7:0]  rx_byte,
  input  logic        rx_eop,
  input  logic        rx_err,
  output logic        rx_pkt_start,
  output logic        rx_pkt_end,
  output logic        rx_pkt_valid,
  output logic [3:0]  rx_pid,
  output logic [6:0]  rx_addr,
  output logic [3:0]  rx_endp,
  output logic [10:0] rx_frame_num,
  output logic        rx_data_put,
  output logic [7:0]  rx_data
);

  localparam int CW = $clog2(MAX_PKT_BYTES + 4);
  localparam logic [CW-1:0] CNT_SAT   = '1;
  localparam logic [CW-1:0] DATA_LAST = CW'(MAX_PKT_BYTES + 2);
  localparam logic [CW-1:0] DATA_MAXN = CW'(MAX_PKT_BYTES + 3);
  localparam logic [CW-1:0] LEN_ONE   = CW'(1);
  localparam logic [CW-1:0] LEN_THREE = CW'(3);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PID  = 3'd1;
  localparam logic [2:0] S_TOK1 = 3'd2;
  localparam logic [2:0] S_TOK2 = 3'd3;
  localparam logic [2:0] S_TEND = 3'd4;
  localparam logic [2:0] S_DATA = 3'd5;
  localparam logic [2:0] S_HS   = 3'd6;

  logic [2:0]    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [4:0]    crc5, crc5_nxt;
  logic [15:0]   crc16, crc16_nxt;
  logic          pid_ok, pid_ok_nxt;
  logic          err_seen, err_nxt;
  logic [7:0]    tok1;
  logic          take, len_crc_ok, end_valid;

  function automatic logic [4:0] crc5_byte(input logic [4:0] c, input logic [7:0] d);
    logic [4:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (d[i] ^ r[4]) r = {r[3:0], 1'b0} ^ 5'h05;
      else             r = {r[3:0], 1'b0};
    end
    return r;
  endfunction

  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (d[i] ^ r[15]) r = {r[14:0], 1'b0} ^ 16'h8005;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  // Byte effects are resolved combinationally so a byte sharing its cycle with rx_eop is judged too.
  always_comb begin
    take       = rx_byte_valid && (state != S_IDLE) && !rx_sop;
    state_nxt  = state;
    cnt_nxt    = cnt;
    crc5_nxt   = crc5;
    crc16_nxt  = crc16;
    pid_ok_nxt = pid_ok;
    if (take) begin
      if (cnt != CNT_SAT) cnt_nxt = cnt + 1'b1;
      case (state)
        S_PID: begin
          pid_ok_nxt = (rx_byte[7:4] == ~rx_byte[3:0]);
          case (rx_byte[1:0])
            2'b01:   state_nxt = S_TOK1;
            2'b11:   state_nxt = S_DATA;
            default: state_nxt = S_HS;
          endcase
        end
        S_TOK1: begin
          crc5_nxt  = crc5_byte(crc5, rx_byte);
          state_nxt = S_TOK2;
        end
        S_TOK2: begin
          crc5_nxt  = crc5_byte(crc5, rx_byte);
          state_nxt = S_TEND;
        end
        S_DATA:  crc16_nxt = crc16_byte(crc16, rx_byte);
        default: ;
      endcase
    end
    err_nxt = err_seen | rx_err;
    case (state_nxt)
      S_TOK1, S_TOK2, S_TEND: len_crc_ok = (cnt_nxt == LEN_THREE) && (crc5_nxt == 5'b01100);
      S_DATA:  len_crc_ok = (cnt_nxt >= LEN_THREE) && (cnt_nxt <= DATA_MAXN) && (crc16_nxt == 16'h800D);
      S_HS:    len_crc_ok = (cnt_nxt == LEN_ONE);
      default: len_crc_ok = 1'b0;
    endcase
    end_valid = pid_ok_nxt && !err_nxt && len_crc_ok;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      crc5         <= 5'h1F;
      crc16        <= 16'hFFFF;
      pid_ok       <= 1'b0;
      err_seen     <= 1'b0;
      tok1         <= '0;
      rx_pkt_start <= 1'b0;
      rx_pkt_end   <= 1'b0;
      rx_pkt_valid <= 1'b0;
      rx_pid       <= '0;
      rx_addr      <= '0;
      rx_endp      <= '0;
      rx_frame_num <= '0;
      rx_data_put  <= 1'b0;
      rx_data      <= '0;
    end else begin
      rx_pkt_start <= 1'b0;
      rx_pkt_end   <= 1'b0;
      rx_pkt_valid <= 1'b0;
      rx_data_put  <= 1'b0;
      if (rx_sop) begin
        // A sop inside a packet means the EOP was lost: close it as invalid and restart.
        if (state != S_IDLE) rx_pkt_end <= 1'b1;
        rx_pkt_start <= 1'b1;
        state        <= S_PID;
        cnt          <= '0;
        crc5         <= 5'h1F;
        crc16        <= 16'hFFFF;
        pid_ok       <= 1'b0;
        err_seen     <= rx_err;
      end else if (state != S_IDLE) begin
        state    <= state_nxt;
        cnt      <= cnt_nxt;
        crc5     <= crc5_nxt;
        crc16    <= crc16_nxt;
        pid_ok   <= pid_ok_nxt;
        err_seen <= err_nxt;
        if (take) begin
          if (state == S_PID)  rx_pid <= rx_byte[3:0];
          if (state == S_TOK1) tok1   <= rx_byte;
          if (state == S_TOK2) begin
            rx_addr      <= tok1[6:0];
            rx_endp      <= {rx_byte[2:0], tok1[7]};
            rx_frame_num <= {rx_byte[2:0], tok1};
          end
          if (state == S_DATA && cnt <= DATA_LAST) begin
            rx_data_put <= 1'b1;
            rx_data     <= rx_byte;
          end
        end
        if (rx_eop) begin
          rx_pkt_end   <= 1'b1;
          rx_pkt_valid <= end_valid;
          state        <= S_IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_usb_fs_rx_pkt_decode.sv
// Bench for usb_fs_rx_pkt_decode: directed packets plus random traffic against a packet-level model
// that builds CRCs with the reflected USB polynomials and judges whole packets.
`timescale 1ns/1ps
module tb_usb_fs_rx_pkt_decode;
  localparam int MAX = 64;
  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic reset, rx_sop, rx_byte_valid, rx_eop, rx_err;
  logic [7:0] rx_byte;
  logic rx_pkt_start, rx_pkt_end, rx_pkt_valid, rx_data_put;
  logic [3:0] rx_pid, rx_endp;
  logic [6:0] rx_addr;
  logic [10:0] rx_frame_num;
  logic [7:0] rx_data;

  always #5 clk = ~clk;

  usb_fs_rx_pkt_decode #(.MAX_PKT_BYTES(MAX)) dut (
    .clk(clk), .reset(reset), .rx_sop(rx_sop), .rx_byte_valid(rx_byte_valid), .rx_byte(rx_byte),
    .rx_eop(rx_eop), .rx_err(rx_err), .rx_pkt_start(rx_pkt_start), .rx_pkt_end(rx_pkt_end),
    .rx_pkt_valid(rx_pkt_valid), .rx_pid(rx_pid), .rx_addr(rx_addr), .rx_endp(rx_endp),
    .rx_frame_num(rx_frame_num), .rx_data_put(rx_data_put), .rx_data(rx_data)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  int mon_starts = 0, mon_ends = 0, mon_bad_ends = 0, mon_sametick = 0;
  logic mon_valid = 1'b0;
  logic [3:0] mon_pid = '0, mon_endp = '0;
  logic [6:0] mon_addr = '0;
  logic [10:0] mon_frame = '0;
  logic [7:0] mon_puts[$];

  always @(negedge clk) begin
    if (rx_pkt_start) mon_starts++;
    if (rx_pkt_end) begin
      mon_ends++;
      if (!rx_pkt_valid) mon_bad_ends++;
      if (rx_pkt_start) mon_sametick++;
      mon_valid = rx_pkt_valid;
      mon_pid   = rx_pid;
      mon_addr  = rx_addr;
      mon_endp  = rx_endp;
      mon_frame = rx_frame_num;
    end
    if (rx_data_put) mon_puts.push_back(rx_data);
  end

  // Reference CRCs in reflected form; result is the field as sent on the wire.
  function automatic logic [4:0] tok_field(input logic [10:0] d);
    logic [4:0] r;
    r = 5'h1F;
    for (int i = 0; i < 11; i++) r = (r[0] ^ d[i]) ? ((r >> 1) ^ 5'h14) : (r >> 1);
    return ~r;
  endfunction

  function automatic logic [15:0] crc16_usb(input bq_t q, input int lo, input int hi);
    logic [15:0] r;
    r = 16'hFFFF;
    for (int j = lo; j <= hi; j++)
      for (int i = 0; i < 8; i++) r = (r[0] ^ q[j][i]) ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return ~r;
  endfunction

  logic [6:0]  m_addr = '0;
  logic [3:0]  m_endp = '0;
  logic [10:0] m_frame = '0;

  task automatic step();
    @(posedge clk);
    #1;
    rx_sop = 1'b0; rx_byte_valid = 1'b0; rx_eop = 1'b0; rx_err = 1'b0;
  endtask

  task automatic mk_token(input logic [7:0] pidb, input logic [6:0] a, input logic [3:0] e, output bq_t q);
    logic [10:0] d;
    d = {e, a};
    q = {};
    q.push_back(pidb);
    q.push_back(d[7:0]);
    q.push_back({tok_field(d), d[10:8]});
  endtask

  task automatic mk_data(input logic [7:0] pidb, input int len, output bq_t q);
    logic [15:0] c;
    q = {};
    q.push_back(pidb);
    for (int i = 0; i < len; i++) q.push_back(8'($urandom));
    c = crc16_usb(q, 1, len);
    q.push_back(c[7:0]);
    q.push_back(c[15:8]);
  endtask

  task automatic send_pkt(input bq_t b, input int err_idx, input bit eop_last);
    rx_sop = 1'b1;
    step();
    for (int i = 0; i < b.size(); i++) begin
      repeat ($urandom_range(0, 2)) step();
      rx_byte_valid = 1'b1;
      rx_byte = b[i];
      if (i == err_idx) rx_err = 1'b1;
      if (eop_last && i == b.size() - 1) rx_eop = 1'b1;
      step();
    end
    if (!eop_last || b.size() == 0) begin
      rx_eop = 1'b1;
      step();
    end
    step();
    step();
  endtask

  // Sends one packet and compares every observable against the packet-level model.
  task automatic run_pkt(input string tag, input bq_t b, input int err_idx, input bit eop_last);
    int bs, be, bp, n;
    bit ok, pid_ok;
    logic [15:0] c;
    logic [7:0] exp_puts[$];
    bs = mon_starts; be = mon_ends; bp = mon_puts.size();
    send_pkt(b, err_idx, eop_last);
    n = b.size();
    exp_puts = {};
    pid_ok = ((b[0][7:4] ^ b[0][3:0]) == 4'hF);
    case (b[0][1:0])
      2'b01: begin
        if (n >= 3) begin
          m_addr  = b[1][6:0];
          m_endp  = {b[2][2:0], b[1][7]};
          m_frame = {b[2][2:0], b[1]};
        end
        ok = (n == 3) && (b[2][7:3] == tok_field({b[2][2:0], b[1]}));
      end
      2'b11: begin
        for (int i = 1; i < n && i <= MAX + 2; i++) exp_puts.push_back(b[i]);
        ok = 1'b0;
        if (n >= 3 && n <= MAX + 3) begin
          c = crc16_usb(b, 1, n - 3);
          ok = (b[n-2] == c[7:0]) && (b[n-1] == c[15:8]);
        end
      end
      default: ok = (n == 1);
    endcase
    ok = ok && pid_ok && (err_idx < 0);
    check({tag, ".starts"}, mon_starts - bs, 1);
    check({tag, ".ends"}, mon_ends - be, 1);
    check({tag, ".valid"}, mon_valid, ok);
    check({tag, ".pid"}, mon_pid, b[0][3:0]);
    check({tag, ".addr"}, mon_addr, m_addr);
    check({tag, ".endp"}, mon_endp, m_endp);
    check({tag, ".frame"}, mon_frame, m_frame);
    check({tag, ".nput"}, mon_puts.size() - bp, exp_puts.size());
    for (int i = 0; i < exp_puts.size() && bp + i < mon_puts.size(); i++)
      check({tag, ".put"}, mon_puts[bp + i], exp_puts[i]);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t q;
    int bs, be, bp, bb, bt, kind;
    logic [7:0] pids_tok[4];
    pids_tok = '{8'hE1, 8'h69, 8'hA5, 8'h2D};
    reset = 1'b1; rx_sop = 1'b0; rx_byte_valid = 1'b0; rx_eop = 1'b0; rx_err = 1'b0; rx_byte = '0;
    #12;
    check("rst.start", rx_pkt_start, 0);
    check("rst.end", rx_pkt_end, 0);
    check("rst.valid", rx_pkt_valid, 0);
    check("rst.pid", rx_pid, 0);
    check("rst.addr", rx_addr, 0);
    check("rst.endp", rx_endp, 0);
    check("rst.frame", rx_frame_num, 0);
    check("rst.put", rx_data_put, 0);
    check("rst.data", rx_data, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    step();

    // Bytes and eop with no packet open are ignored.
    bs = mon_starts; be = mon_ends; bp = mon_puts.size();
    rx_byte_valid = 1'b1; rx_byte = 8'hC3; step();
    rx_eop = 1'b1; step(); step(); step();
    check("idle.starts", mon_starts - bs, 0);
    check("idle.ends", mon_ends - be, 0);
    check("idle.puts", mon_puts.size() - bp, 0);

    q = '{8'h2D, 8'h00, 8'h10};
    run_pkt("setup", q, -1, 1'b0);
    q = '{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94};
    run_pkt("data0", q, -1, 1'b0);
    check("data0.fixed_valid", mon_valid, 1);
    q[10] = 8'h95;
    run_pkt("data0_bad", q, -1, 1'b0);
    check("data0_bad.fixed_valid", mon_valid, 0);
    q = '{8'hD2};
    run_pkt("ack", q, -1, 1'b0);
    check("ack.fixed_valid", mon_valid, 1);
    q = '{8'h2C};
    run_pkt("pidchk", q, -1, 1'b0);
    mk_token(8'h69, 7'h15, 4'h3, q);
    run_pkt("tok_err", q, 1, 1'b0);
    mk_data(8'h4B, MAX + 1, q);
    run_pkt("oversize", q, -1, 1'b0);
    mk_data(8'hC3, MAX, q);
    run_pkt("maxdata", q, -1, 1'b1);

    // Missed EOP: sop in DATA closes the old packet invalid in the same cycle as the new start.
    bs = mon_starts; be = mon_ends; bp = mon_puts.size(); bb = mon_bad_ends; bt = mon_sametick;
    rx_sop = 1'b1; step();
    rx_byte_valid = 1'b1; rx_byte = 8'hC3; step();
    rx_byte_valid = 1'b1; rx_byte = 8'h80; step();
    rx_byte_valid = 1'b1; rx_byte = 8'h06; step();
    rx_sop = 1'b1; step();
    rx_byte_valid = 1'b1; rx_byte = 8'hD2; step();
    rx_eop = 1'b1; step(); step(); step();
    check("resop.starts", mon_starts - bs, 2);
    check("resop.ends", mon_ends - be, 2);
    check("resop.bad_ends", mon_bad_ends - bb, 1);
    check("resop.sametick", mon_sametick - bt, 1);
    check("resop.last_valid", mon_valid, 1);
    check("resop.nput", mon_puts.size() - bp, 2);

    // sop and eop together while idle: the sop wins.
    bs = mon_starts; be = mon_ends;
    rx_sop = 1'b1; rx_eop = 1'b1; step();
    rx_byte_valid = 1'b1; rx_byte = 8'h5A; step();
    rx_eop = 1'b1; step(); step(); step();
    check("sopeop.starts", mon_starts - bs, 1);
    check("sopeop.ends", mon_ends - be, 1);
    check("sopeop.valid", mon_valid, 1);
    check("sopeop.pid", mon_pid, 4'hA);

    // Async reset mid-token drops the packet with no end pulse.
    be = mon_ends;
    rx_sop = 1'b1; step();
    rx_byte_valid = 1'b1; rx_byte = 8'hE1; step();
    rx_byte_valid = 1'b1; rx_byte = 8'h7F; step();
    #2 reset = 1'b1;
    #1;
    check("arst.pid", rx_pid, 0);
    check("arst.addr", rx_addr, 0);
    check("arst.frame", rx_frame_num, 0);
    check("arst.start", rx_pkt_start, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    rx_byte_valid = 1'b1; rx_byte = 8'h00; step();
    rx_eop = 1'b1; step(); step(); step();
    check("arst.ends", mon_ends - be, 0);
    m_addr = '0; m_endp = '0; m_frame = '0;

    for (int t = 0; t < 150; t++) begin
      kind = $urandom_range(0, 7);
      case (kind)
        0, 1: mk_token(pids_tok[$urandom_range(0, 3)], 7'($urandom), 4'($urandom), q);
        2, 3: mk_data($urandom_range(0, 1) ? 8'hC3 : 8'h4B, $urandom_range(0, MAX), q);
        4: begin
          q = {};
          q.push_back($urandom_range(0, 3) == 0 ? 8'($urandom) : ($urandom_range(0, 1) ? 8'hD2 : 8'h5A));
          if ($urandom_range(0, 3) == 0) q.push_back(8'($urandom));
        end
        5: begin
          mk_token(pids_tok[$urandom_range(0, 3)], 7'($urandom), 4'($urandom), q);
          if ($urandom_range(0, 1) == 1) void'(q.pop_back());
          else q.push_back(8'($urandom));
        end
        6: begin
          mk_data(8'hC3, $urandom_range(0, MAX), q);
          q = {q[0]};
          q.push_back(8'($urandom));
        end
        default: mk_data(8'h4B, $urandom_range(MAX - 2, MAX + 2), q);
      endcase
      if (kind == 1 || kind == 3) begin
        bb = $urandom_range(1, q.size() - 1);
        q[bb] = q[bb] ^ (8'h01 << $urandom_range(0, 7));
      end
      run_pkt("rnd", q, ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, q.size() - 1)) : -1,
              1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
